vedic_seq_mult_ctrl: RTL
========================

Name: vedic_seq_mult_ctrl

Overview:
- Sequential WIDTH x WIDTH unsigned multiplier controller.
- Time-multiplexes a single 2x2 vedic multiplier core (instantiated internally) over all 2-bit digit pairs of the two operands, shifting and accumulating the partial products.
- Valid/ready handshake on both the operand side and the result side; sits between an operand source and a result consumer in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. N = WIDTH/2 digits per operand.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b present
- in_ready  output  1  controller can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand, unsigned
- b  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b, unsigned
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; counter=0; accumulator=0; captured operands=0; product=0; out_valid=0; busy=0; in_ready=0 while rst is high, 1 after release.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1 (combinational from state).
  - On an edge with in_valid&&in_ready, capture a and b into internal registers, clear the accumulator and counter, and go to RUN.
  - a and b are ignored at all other times.
- RUN:
  - counter c runs 0..N*N-1; i=c/N, j=c%N.
  - Core inputs: A digit i (bits 2i+1:2i) and B digit j.
  - Each edge: acc <= acc + (core_out << 2*(i+j)); c <= c+1.
  - On the edge with c==N*N-1, go to DONE and load product with the final sum.
  - Accumulator width is 2*WIDTH; the sum never overflows.
- DONE:
  - out_valid=1; product held stable.
  - On an edge with out_valid&&out_ready, go to IDLE; out_valid=0 from the next cycle. product retains its value until the next result is loaded.
- Latency: out_valid rises N*N edges after the accept edge (16 for WIDTH=8, 1 for WIDTH=2).
- No overlap: in_ready=0 in RUN/DONE, so the next accept is possible only in the cycle after the handshake edge. Throughput is one result per N*N+2 cycles with out_ready held high.
- Backpressure: DONE persists indefinitely while out_ready=0; product must not change.
- in_valid during RUN/DONE has no effect and must not corrupt the captured operands.
- Reset mid-operation: abandon immediately to the reset state; no partial result is ever presented.
- out_ready while not in DONE is ignored.
- WIDTH odd or < 2 is illegal; elaboration must fail via a generate-time check.

Optional Feature:
- Macro: VEDIC_SEQ_EARLY_ZERO_EN.
- Defined: if the captured a==0 or b==0 at the accept edge, go directly from IDLE to DONE with product=0. out_valid rises 1 edge after accept; RUN is skipped.
- Undefined: zero operands take the full N*N RUN cycles, then product=0.
- Non-zero operands behave identically in both builds.

Test Plan:
- WIDTH=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid rises exactly 16 edges after accept; product=0xFE01; in_ready returns to 1 the cycle after the handshake.
- WIDTH=8, a=0x0D, b=0x0B; out_ready low 5 cycles after out_valid -> product=0x008F held stable throughout; in_ready=0; the handshake completes on the first edge with out_ready=1.
- WIDTH=8, accept 0xAA*0x55, assert rst 7 edges into RUN -> out_valid=0, product=0, state IDLE. Then accept 0x12*0x34 -> product=0x03A8 after 16 edges.
- WIDTH=8, a=0x00, b=0x5A -> product=0x0000. out_valid after 1 edge with VEDIC_SEQ_EARLY_ZERO_EN defined, after 16 edges without.
- WIDTH=8, in_valid held high with a/b changing every cycle during RUN -> result equals the product of the operands captured at the accept edge only.
- WIDTH=4, a=0xF, b=0xF -> product=0xE1 after 4 edges. WIDTH=2, a=3, b=2 -> product=6 after 1 edge.

Source files
------------

// File: rtl/vedic_seq_mult_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier built by time-multiplexing one 2x2 vedic core.
// Optional macro VEDIC_SEQ_EARLY_ZERO_EN: a zero operand skips RUN and returns product 0 at once.

module vedic_2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_prod_c
);
  logic w_c1;
  logic w_hh;

  // Urdhva-tiryagbhyam: vertical, crosswise, vertical with carry ripple
  assign w_hh        = i_a[1] & i_b[1];
  assign w_c1        = (i_a[1] & i_b[0]) & (i_a[0] & i_b[1]);
  assign o_prod_c[0] = i_a[0] & i_b[0];
  assign o_prod_c[1] = (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]);
  assign o_prod_c[2] = w_hh ^ w_c1;
  assign o_prod_c[3] = w_hh & w_c1;
endmodule

module vedic_seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int unsigned N  = WIDTH / 2;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned DW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned SW = $clog2(PW) + 1;

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
      $error("vedic_seq_mult_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_product;
  logic [DW-1:0]     r_di;
  logic [DW-1:0]     r_dj;

  logic              w_accept;
  logic              w_skip;
  logic              w_last;
  logic [WIDTH-1:0]  w_a_sh;
  logic [WIDTH-1:0]  w_b_sh;
  logic [3:0]        w_core;
  logic [SW-1:0]     w_shamt;
  logic [PW-1:0]     w_acc_nxt;

  assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef VEDIC_SEQ_EARLY_ZERO_EN
  assign w_skip = (a == '0) || (b == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_last = (r_di == DW'(N - 1)) && (r_dj == DW'(N - 1));

  // Digit i of A against digit j of B, weighted by 4^(i+j)
  assign w_a_sh    = r_a >> {r_di, 1'b0};
  assign w_b_sh    = r_b >> {r_dj, 1'b0};
  assign w_shamt   = (SW'(r_di) + SW'(r_dj)) << 1;
  assign w_acc_nxt = r_acc + (PW'(w_core) << w_shamt);

  vedic_2x2 u_core (
    .i_a      (w_a_sh[1:0]),
    .i_b      (w_b_sh[1:0]),
    .o_prod_c (w_core)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = !rst;
        if (w_accept) w_state_nxt = w_skip ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, digit sweep and accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_di      <= '0;
      r_dj      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_di  <= '0;
            r_dj  <= '0;
            if (w_skip) r_product <= '0;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          if (r_dj == DW'(N - 1)) begin
            r_dj <= '0;
            r_di <= r_di + DW'(1);
          end else begin
            r_dj <= r_dj + DW'(1);
          end
          if (w_last) r_product <= w_acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign product = r_product;
endmodule
